// File: rtl/alu_cmd_frontend.sv
// Byte-stream command front end for the calculator ALU: parses 10-byte command
// frames, drives the ALU operands/opcode, and returns a 6-byte response frame.
module alu_cmd_frontend #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int ALU_LATENCY = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] alu_p,
    output logic [DATA_W-1:0] alu_q,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [1:0]        alu_error,
    output logic              busy,
    output logic              frame_err
);

    localparam int NB      = DATA_W / 8;
    localparam int RESP_NB = 2 + NB;
    localparam int RESP_W  = 8 * RESP_NB;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);
    localparam int EXC_W   = $clog2(ALU_LATENCY + 2);
    localparam int TXC_W   = $clog2(RESP_NB);

    localparam logic [7:0]       SOF_CMD  = 8'hA5;
    localparam logic [7:0]       SOF_RSP  = 8'h5A;
    localparam logic [OP_W-1:0]  OP_RESET = OP_W'(4'b1100);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       BYTE_LAST = 4'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        P_BYTES,
        Q_BYTES,
        EXEC,
        TX
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [EXC_W-1:0]  exec_cnt_q, exec_cnt_d;
    logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [OP_W-1:0]   op_asm_q, op_asm_d;
    logic [DATA_W-1:0] p_asm_q, p_asm_d;
    logic [DATA_W-1:0] q_asm_q, q_asm_d;
    logic [DATA_W-1:0] alu_p_q, alu_p_d;
    logic [DATA_W-1:0] alu_q_q, alu_q_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              frame_err_q, frame_err_d;

    logic in_frame;
    logic rx_fire;
    logic tx_fire;

    assign in_frame  = (state_q == OPC) || (state_q == P_BYTES) || (state_q == Q_BYTES);
    assign rx_ready  = (state_q == IDLE) || in_frame;
    assign tx_valid  = (state_q == TX);
    assign tx_data   = tx_valid ? resp_q[RESP_W-1 -: 8] : 8'h00;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign alu_p     = alu_p_q;
    assign alu_q     = alu_q_q;
    assign alu_op    = alu_op_q;
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        timer_d     = timer_q;
        exec_cnt_d  = exec_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        op_asm_d    = op_asm_q;
        p_asm_d     = p_asm_q;
        q_asm_d     = q_asm_q;
        alu_p_d     = alu_p_q;
        alu_q_d     = alu_q_q;
        alu_op_d    = alu_op_q;
        resp_d      = resp_q;
        frame_err_d = 1'b0;

        // Inter-byte watchdog shared by all frame-assembly states
        if (in_frame) begin
            timer_d = rx_fire ? '0 : timer_q + TMR_W'(1);
            if (!rx_fire && timer_q == TMR_LAST) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rx_fire && rx_data == SOF_CMD) begin
                    state_d = OPC;
                end
            end
            OPC: begin
                if (rx_fire) begin
                    if (rx_data[7:OP_W] != '0) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end else begin
                        op_asm_d   = rx_data[OP_W-1:0];
                        byte_cnt_d = '0;
                        state_d    = P_BYTES;
                    end
                end
            end
            P_BYTES: begin
                if (rx_fire) begin
                    p_asm_d = (p_asm_q << 8) | DATA_W'(rx_data);
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = Q_BYTES;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            Q_BYTES: begin
                if (rx_fire) begin
                    q_asm_d = (q_asm_q << 8) | DATA_W'(rx_data);
                    if (byte_cnt_q == BYTE_LAST) begin
                        // All three ALU inputs switch on the same edge
                        alu_p_d    = p_asm_q;
                        alu_q_d    = (q_asm_q << 8) | DATA_W'(rx_data);
                        alu_op_d   = op_asm_q;
                        byte_cnt_d = '0;
                        exec_cnt_d = '0;
                        state_d    = EXEC;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            EXEC: begin
                if (exec_cnt_q == EXC_W'(ALU_LATENCY)) begin
                    resp_d   = {SOF_RSP, 6'b0, alu_error, alu_result};
                    tx_cnt_d = '0;
                    state_d  = TX;
                end else begin
                    exec_cnt_d = exec_cnt_q + EXC_W'(1);
                end
            end
            TX: begin
                if (tx_fire) begin
                    resp_d = resp_q << 8;
                    if (tx_cnt_q == TXC_W'(RESP_NB - 1)) begin
                        state_d = IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + TXC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            exec_cnt_q  <= '0;
            tx_cnt_q    <= '0;
            op_asm_q    <= '0;
            p_asm_q     <= '0;
            q_asm_q     <= '0;
            alu_p_q     <= '0;
            alu_q_q     <= '0;
            alu_op_q    <= OP_RESET;
            resp_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            timer_q     <= timer_d;
            exec_cnt_q  <= exec_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            op_asm_q    <= op_asm_d;
            p_asm_q     <= p_asm_d;
            q_asm_q     <= q_asm_d;
            alu_p_q     <= alu_p_d;
            alu_q_q     <= alu_q_d;
            alu_op_q    <= alu_op_d;
            resp_q      <= resp_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
